// File: rtl/io_input_arbiter.sv
// io_input_arbiter: grants the shared G-15 input character path to one of five
// input devices (0 tape, 1 photo, 2 type, 3 mag, 4 card) for a whole block and
// forwards the owner's 5-bit frames as single-cycle pulses toward OB1-OB5.
// Optional feature: define IO_ARB_TIMEOUT_EN to enable forced release of an
// owner that stays silent for TIMEOUT_CYCLES WAIT cycles.
//
// Handshake: dev_req[i] is the device's valid; the arbiter is ready for device i
// only while i owns the grant, the state is WAIT and DIG_SLOT is high. A frame
// is taken in the cycle valid and ready are both high; dev_ack[i] pulses on the
// following cycle, and the device must hold dev_code/dev_eob until that ack.
module io_input_arbiter #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        CLOCK,
  input  logic        rst_n,
  input  logic        IN,
  input  logic        READY,
  input  logic        DIG_SLOT,
  input  logic [4:0]  dev_req,
  input  logic [24:0] dev_code,
  input  logic [4:0]  dev_eob,
  output logic [4:0]  dev_ack,
  output logic [4:0]  IN_CODE,
  output logic [4:0]  GRANT,
  output logic        BUSY,
  output logic        TIMEOUT,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [4:0] grant_q, grant_n;
  logic [2:0] owner_q, owner_n;
  logic [2:0] last_q, last_n;
  logic [4:0] code_q, code_n;
  logic [4:0] ack_q, ack_n;
  logic       busy_q, busy_n;
  logic [2:0] pick;
  logic [4:0] owner_code;
  logic       abort;

`ifdef IO_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q, cnt_n;
  logic        timeout_q, timeout_n;
`endif

  // Index arithmetic modulo 5 for the round-robin search.
  function automatic logic [2:0] mod5(input logic [3:0] v);
    if (v >= 4'd5) return 3'(v - 4'd5);
    else           return 3'(v);
  endfunction

  assign abort = ~IN | READY;

  // Round-robin pick: the first requester after `last`, `last` itself lowest.
  always_comb begin
    pick = last_q;
    for (int k = 5; k >= 1; k--) begin
      if (dev_req[mod5({1'b0, last_q} + 4'(k))]) pick = mod5({1'b0, last_q} + 4'(k));
    end
  end

  // Select the current owner's frame from the packed code bus.
  always_comb begin
    owner_code = '0;
    for (int i = 0; i < 5; i++) begin
      if (owner_q == 3'(i)) owner_code = dev_code[i*5 +: 5];
    end
  end

  // Next-state and registered-output computation; abort outranks transfer,
  // transfer outranks timeout.
  always_comb begin
    state_n = state;
    grant_n = grant_q;
    owner_n = owner_q;
    last_n  = last_q;
    code_n  = '0;
    ack_n   = '0;
`ifdef IO_ARB_TIMEOUT_EN
    cnt_n     = cnt_q;
    timeout_n = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (IN && !READY && (|dev_req)) begin
          owner_n = pick;
          grant_n = 5'b00001 << pick;
          state_n = S_WAIT;
`ifdef IO_ARB_TIMEOUT_EN
          cnt_n = '0;
`endif
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_n = S_IDLE;
          grant_n = '0;
          last_n  = owner_q;
        end else if (DIG_SLOT && dev_req[owner_q]) begin
          code_n         = owner_code;
          ack_n[owner_q] = 1'b1;
`ifdef IO_ARB_TIMEOUT_EN
          cnt_n = '0;
`endif
          if (dev_eob[owner_q]) begin
            grant_n = '0;
            last_n  = owner_q;
            state_n = S_DONE;
          end
        end
`ifdef IO_ARB_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          timeout_n = 1'b1;
          grant_n   = '0;
          last_n    = owner_q;
          state_n   = S_IDLE;
        end else begin
          cnt_n = cnt_q + 16'd1;
        end
`endif
      end
      S_DONE: begin
        state_n = S_IDLE;
        grant_n = '0;
        if (abort) last_n = owner_q;
      end
      default: begin
        state_n = S_IDLE;
        grant_n = '0;
      end
    endcase
    busy_n = (state_n != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge CLOCK) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      last_q  <= 3'd4;
      code_q  <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      owner_q <= owner_n;
      last_q  <= last_n;
      code_q  <= code_n;
      ack_q   <= ack_n;
      busy_q  <= busy_n;
    end
  end

`ifdef IO_ARB_TIMEOUT_EN
  // Silent-owner watchdog counter and its release pulse.
  always_ff @(posedge CLOCK) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_n;
      timeout_q <= timeout_n;
    end
  end
  assign TIMEOUT = timeout_q;
`else
  assign TIMEOUT = 1'b0;
`endif

  assign GRANT     = grant_q;
  assign IN_CODE   = code_q;
  assign dev_ack   = ack_q;
  assign BUSY      = busy_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_io_input_arbiter.sv
// tb_io_input_arbiter: directed vectors for io_input_arbiter with hand-computed
// expectations. Inputs change 1 ns after each rising edge; outputs are checked
// at that same point, reflecting the inputs of the previous cycle.
module tb_io_input_arbiter;

  logic        CLOCK = 1'b0;
  logic        rst_n;
  logic        IN;
  logic        READY;
  logic        DIG_SLOT;
  logic [4:0]  dev_req;
  logic [24:0] dev_code;
  logic [4:0]  dev_eob;
  logic [4:0]  dev_ack;
  logic [4:0]  IN_CODE;
  logic [4:0]  GRANT;
  logic        BUSY;
  logic        TIMEOUT;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  io_input_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .CLOCK(CLOCK), .rst_n(rst_n), .IN(IN), .READY(READY), .DIG_SLOT(DIG_SLOT),
    .dev_req(dev_req), .dev_code(dev_code), .dev_eob(dev_eob),
    .dev_ack(dev_ack), .IN_CODE(IN_CODE), .GRANT(GRANT), .BUSY(BUSY),
    .TIMEOUT(TIMEOUT), .dbg_state(dbg_state)
  );

  // Clock / reset block
  always #5 CLOCK = ~CLOCK;

  task automatic tick();
    @(posedge CLOCK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [4:0] exp_code;
    rst_n = 1'b0; IN = 1'b0; READY = 1'b0; DIG_SLOT = 1'b0;
    dev_req = '0; dev_code = '0; dev_eob = '0;
    tick(); tick();
    check("rst_grant", 32'(GRANT), 0);
    check("rst_code", 32'(IN_CODE), 0);
    check("rst_ack", 32'(dev_ack), 0);
    check("rst_busy", 32'(BUSY), 0);
    check("rst_timeout", 32'(TIMEOUT), 0);
    check("rst_state", 32'(dbg_state), 0);
    rst_n = 1'b1;
    tick();

    // Single device 2, three frames, last one with eob
    IN = 1'b1; dev_req = 5'b00100; dev_code[14:10] = 5'h0A;
    tick();
    check("single_grant", 32'(GRANT), 32'h04);
    check("single_busy", 32'(BUSY), 1);
    check("single_state", 32'(dbg_state), 1);
    for (int f = 0; f < 3; f++) begin
      DIG_SLOT = 1'b1;
      if (f == 2) dev_eob = 5'b00100;
      tick();
      check("frame_code", 32'(IN_CODE), 32'h0A);
      check("frame_ack", 32'(dev_ack), 32'h04);
      DIG_SLOT = 1'b0; dev_eob = '0;
      if (f < 2) begin
        tick();
        check("frame_code_pulse", 32'(IN_CODE), 0);
        check("frame_ack_pulse", 32'(dev_ack), 0);
        check("frame_grant_hold", 32'(GRANT), 32'h04);
      end
    end
    // Now at m+1 after the eob slot
    check("eob_grant", 32'(GRANT), 0);
    check("eob_busy_done", 32'(BUSY), 1);
    check("eob_state_done", 32'(dbg_state), 2);
    tick();
    check("eob_busy_idle", 32'(BUSY), 0);
    check("eob_grant_m2", 32'(GRANT), 0);
    tick();
    check("regrant_m3", 32'(GRANT), 32'h04);

    // Abort coincident with an owner frame
    DIG_SLOT = 1'b1; READY = 1'b1;
    tick();
    check("abort_ack", 32'(dev_ack), 0);
    check("abort_code", 32'(IN_CODE), 0);
    check("abort_grant", 32'(GRANT), 0);
    check("abort_busy", 32'(BUSY), 0);
    READY = 1'b0; DIG_SLOT = 1'b0; dev_req = '0;
    tick();

    // Reset mid-block with a pending frame
    dev_req = 5'b00100;
    tick();
    check("pre_reset_grant", 32'(GRANT), 32'h04);
    rst_n = 1'b0; DIG_SLOT = 1'b1;
    tick();
    check("midrst_grant", 32'(GRANT), 0);
    check("midrst_ack", 32'(dev_ack), 0);
    check("midrst_code", 32'(IN_CODE), 0);
    check("midrst_busy", 32'(BUSY), 0);
    rst_n = 1'b1; DIG_SLOT = 1'b0; dev_req = '0;
    tick();

    // Round robin: everyone requests, one-frame blocks
    dev_req = 5'b11111; dev_eob = 5'b11111; DIG_SLOT = 1'b1;
    for (int i = 0; i < 5; i++) dev_code[i*5 +: 5] = 5'(5'h10 + i);
    for (int k = 0; k < 6; k++) begin
      int d;
      d = k % 5;
      tick();
      check("rr_grant", 32'(GRANT), 32'(1 << d));
      tick();
      exp_code = 5'(5'h10 + d);
      check("rr_code", 32'(IN_CODE), 32'(exp_code));
      check("rr_ack", 32'(dev_ack), 32'(1 << d));
      if (k == 5) dev_req = '0;
      tick();
      check("rr_idle", 32'(BUSY), 0);
    end
    DIG_SLOT = 1'b0; dev_eob = '0;
    tick();

    // Non-owner isolation: owner 1 silent, device 3 requesting
    dev_req = 5'b00010;
    tick();
    check("iso_grant", 32'(GRANT), 32'h02);
    dev_req = 5'b01000; DIG_SLOT = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("iso_code", 32'(IN_CODE), 0);
      check("iso_ack", 32'(dev_ack), 0);
      check("iso_grant_hold", 32'(GRANT), 32'h02);
    end
    DIG_SLOT = 1'b0; dev_req = '0; IN = 1'b0;
    tick();
    check("in_drop_grant", 32'(GRANT), 0);
    IN = 1'b1;
    tick();

    // Silent owner 0 after grant
    dev_req = 5'b00001;
    tick();
    check("to_grant", 32'(GRANT), 32'h01);
    dev_req = '0;
`ifdef IO_ARB_TIMEOUT_EN
    for (int c = 1; c < 8; c++) begin
      tick();
      check("to_wait_timeout", 32'(TIMEOUT), 0);
      check("to_wait_grant", 32'(GRANT), 32'h01);
    end
    tick();
    check("to_pulse", 32'(TIMEOUT), 1);
    check("to_grant_clear", 32'(GRANT), 0);
    check("to_state_idle", 32'(dbg_state), 0);
    tick();
    check("to_pulse_end", 32'(TIMEOUT), 0);
`else
    for (int c = 0; c < 20; c++) begin
      tick();
      check("hold_grant", 32'(GRANT), 32'h01);
      check("hold_timeout", 32'(TIMEOUT), 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
